// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle divide unit and the EX-stage decode
// that launches it.
package div_pkg;

  // Sequencer states: waiting for a divide, iterating, presenting the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Native operand width of the MIPS datapath.
  localparam int DIV_WIDTH = 32;

  // Quotient reported when the divisor is zero.
  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

  // alucontrol encodings shared with aludec, so EX decode of start/signed_div
  // can never drift from the main decoder.
  localparam logic [3:0] ALUCTRL_DIV  = 4'b1110;
  localparam logic [3:0] ALUCTRL_DIVU = 4'b1111;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quo} left by one, then keep
// the trial difference when the divisor fits and record a quotient 1 bit.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   nextRem,
  output logic [WIDTH-1:0] nextQuo
);

  logic [WIDTH+1:0] shiftedRem;
  logic [WIDTH+1:0] trialDiff;

  // Shift, trial-subtract, and restore when the difference goes negative.
  always_comb begin
    shiftedRem = {rem, quo[WIDTH-1]};
    trialDiff  = shiftedRem - {2'b00, divisor};
    nextQuo    = {quo[WIDTH-2:0], 1'b0};
    nextRem    = shiftedRem[WIDTH:0];
    if (!trialDiff[WIDTH+1]) begin
      nextRem    = trialDiff[WIDTH:0];
      nextQuo[0] = 1'b1;
    end
  end

endmodule

// File: rtl/div_sequencer.sv
// Execute-stage sequencer for DIV/DIVU: latches operand magnitudes, runs one
// restoring iteration per cycle, and stalls the pipeline until the signed-fixed
// {remainder, quotient} is ready for HI/LO.
module div_sequencer
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic               flush,
  input  logic [WIDTH-1:0]   opa,
  input  logic [WIDTH-1:0]   opb,
  output logic               stall_div,
  output logic               ready,
  output logic [2*WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);

  div_state_t       state;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] divisor;
  logic [CW-1:0]    count;
  logic             negRem;
  logic             negQuo;
  logic             isSigned;

  logic [WIDTH:0]   nextRem;
  logic [WIDTH-1:0] nextQuo;
  logic [WIDTH-1:0] absA;
  logic [WIDTH-1:0] absB;
  logic [WIDTH-1:0] fixQuo;
  logic [WIDTH-1:0] fixRem;

  // Operand magnitudes; unsigned divides pass the operands straight through.
  always_comb begin
    absA = opa;
    absB = opb;
    if (signed_div && opa[WIDTH-1]) absA = -opa;
    if (signed_div && opb[WIDTH-1]) absB = -opb;
  end

  // Sign correction applied to the final iteration's outputs as they are registered.
  always_comb begin
    fixQuo = nextQuo;
    fixRem = nextRem[WIDTH-1:0];
    if (isSigned && negQuo) fixQuo = -nextQuo;
    if (isSigned && negRem) fixRem = -nextRem[WIDTH-1:0];
  end

  div_step #(.WIDTH(WIDTH)) uStep (
    .rem     (rem),
    .quo     (quo),
    .divisor (divisor),
    .nextRem (nextRem),
    .nextQuo (nextQuo)
  );

  // Freeze the pipeline while a divide is being launched or is iterating.
  assign stall_div = ~flush & (((state == IDLE) & start) | (state == BUSY));

  // Control FSM and datapath registers; flush aborts without touching result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rem      <= '0;
      quo      <= '0;
      divisor  <= '0;
      count    <= '0;
      negRem   <= 1'b0;
      negQuo   <= 1'b0;
      isSigned <= 1'b0;
      ready    <= 1'b0;
      result   <= '0;
    end else if (flush) begin
      state <= IDLE;
      count <= '0;
      ready <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ready <= 1'b0;
          if (start) begin
            if (opb == '0) begin
              result <= {opa, {WIDTH{1'b1}}};
              ready  <= 1'b1;
              state  <= DONE;
            end else begin
              rem      <= '0;
              quo      <= absA;
              divisor  <= absB;
              count    <= '0;
              negRem   <= opa[WIDTH-1];
              negQuo   <= opa[WIDTH-1] ^ opb[WIDTH-1];
              isSigned <= signed_div;
              state    <= BUSY;
            end
          end
        end
        BUSY: begin
          rem   <= nextRem;
          quo   <= nextQuo;
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) begin
            result <= {fixRem, fixQuo};
            ready  <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          ready <= 1'b0;
          state <= IDLE;
        end
        default: begin
          ready <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Multi-cycle sequencer for MIPS DIV/DIVU in the execute stage. It latches operands when a divide enters EX, runs a 32-iteration restoring division over an internal datapath, and holds `stall_div` high so the pipeline freezes until the result is ready. The 64-bit result (`{remainder, quotient}`) feeds the ALU's 64-bit output path that writes HI/LO.

## Interface
Parameters:
- `WIDTH`, 32: operand width; the iteration count equals `WIDTH`.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: a divide op is present in EX (decoded from `alucontrolE`); held high by the stalled pipeline.
- `signed_div` in 1: 1 = DIV, 0 = DIVU; sampled with `start`.
- `flush` in 1: annul the EX instruction and abort any division.
- `opa` in WIDTH: dividend (`rs`, after forwarding).
- `opb` in WIDTH: divisor (`rt`, after forwarding).
- `stall_div` out 1: freeze request to the hazard unit.
- `ready` out 1: one-cycle pulse; `result` is valid.
- `result` out 2*WIDTH: `[63:32]` remainder (to HI), `[31:0]` quotient (to LO).

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - If `start & ~flush` and `opb != 0`: latch `|opa|` and `|opb|` (magnitudes only when `signed_div`), the sign of `opa`, the sign of `opa ^ opb`, and `signed_div`. Clear the partial remainder and count, then go to BUSY.
  - If `start & ~flush` and `opb == 0`: go to DONE with `result = {opa, 32'hFFFF_FFFF}` (defined divide-by-zero value).
- BUSY, one iteration per cycle:
  - Shift `{rem, quo}` left by 1.
  - Trial `rem - divisor`; if non-negative, keep the difference and set `quo[0]=1`.
  - `count` increments 0..31. When `count == 31`, go to DONE.
- DONE:
  - Register `result` with sign fix: quotient negated if the latched sign-differ bit is set; remainder negated if the dividend was negative (signed only).
  - `ready=1` for this cycle only, then return to IDLE.
  - `start` is ignored in DONE, because the same instruction is still in EX; this prevents a re-launch.
- `stall_div = ~flush & ((IDLE & start) | BUSY)`. It is low in DONE, so the pipeline advances exactly when `ready` pulses.
- `flush` in any state: next state IDLE, `ready` not asserted, `result` unchanged. `flush` has priority over `start`.
- `result` holds its value until the next DONE.
- Arithmetic details:
  - The partial remainder is WIDTH+1 bits, so the trial subtraction never overflows.
  - `0x80000000 / 0xFFFFFFFF` signed yields quotient `0x80000000`, remainder 0. This wraps naturally with no special case.

## Timing
- Reset: state IDLE, `count=0`, `result=0`, `ready=0`. `stall_div=0` (provided `start=0`).
- Normal divide, with cycle 0 being the first cycle `start` is high in IDLE:
  - `stall_div` high in cycles 0..32.
  - BUSY covers cycles 1..32.
  - DONE is cycle 33: `ready=1`, `stall_div=0`, `result` valid from cycle 33 onward.
  - Latency is 33 cycles to result.
- Divide by zero: `stall_div` high in cycle 0 only; DONE/`ready` in cycle 1.
- Back-to-back divides: the second `start` is recognised in the IDLE cycle after DONE (cycle 34).
- `rst` mid-BUSY: IDLE on the next edge, `result=0`, no `ready`.

## Structure
- Shared package `div_pkg`:
  - State enum `div_state_t` {IDLE, BUSY, DONE}.
  - `DIV_WIDTH=32`.
  - `DIV0_QUOT=32'hFFFF_FFFF`.
  - The alucontrol codes for DIV/DIVU, so that EX decode of `start`/`signed_div` uses the same constants as `aludec`.
- Sub-module `div_step`: combinational single restoring iteration (rem, quo, divisor → next rem, next quo). Instantiated once; the FSM and registers live in `div_sequencer`.

## Test plan
- DIVU 100 / 7 → `stall_div` high cycles 0..32, `ready` at cycle 33, `result = 0x00000002_0000000E`.
- DIV −7 / 2 (`0xFFFFFFF9`, 2) → `result = 0xFFFFFFFF_FFFFFFFD`. DIV 7 / −2 → `0x00000001_FFFFFFFD`.
- DIV `0x80000000` / `0xFFFFFFFF` → `result = 0x00000000_80000000`. DIVU `0xFFFFFFFF` / 1 → `0x00000000_FFFFFFFF`.
- DIVU 5 / 0 → `ready` at cycle 1, `result = 0x00000005_FFFFFFFF`, `stall_div` high for 1 cycle.
- Start DIVU 100/7, pulse `flush` in cycle 10 → IDLE at 11, no `ready`, `result` unchanged. New start DIVU 9/3 at cycle 12 → `ready` at cycle 45, `result = 0x00000000_00000003`.
- `start` held high through DONE → exactly one `ready` pulse, no re-launch. Assert `rst` in cycle 20 of a divide → all outputs 0 next cycle.
